// File: rtl/axilm_pkg.sv
// Shared types and constants for the AXI4-Lite master local-bus arbiter.
// Holds the arbiter state encoding and the AXI response codes.
package axilm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Reads report RRESP, writes report BRESP.
  function automatic logic [1:0] sel_resp(input logic       is_read,
                                          input logic [1:0] rresp,
                                          input logic [1:0] bresp);
    return is_read ? rresp : bresp;
  endfunction

endpackage

// File: rtl/axilm_rr_pick.sv
// Combinational round-robin winner select: the first set request at or
// after ptr (wrapping modulo N) wins.
module axilm_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx,
  output logic          win_any
);

  logic [2*N-1:0] req2;
  logic [IW:0]    ptr_x;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;

  // Duplicating the vector turns the circular scan into a plain slice.
  assign req2  = {req, req};
  assign ptr_x = {1'b0, ptr};
  assign rot   = req2[ptr_x +: N];

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = IW'(i);
      end
    end
  end

  assign win_any = |rot;
  assign sum     = {1'b0, ptr} + {1'b0, off};
  assign win_idx = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : IW'(sum);
  assign win     = win_any ? ({{(N - 1){1'b0}}, 1'b1} << win_idx) : '0;

endmodule

// File: rtl/axilm_arb.sv
// Round-robin arbiter sharing one AXI4-Lite master local bus among N
// requesters, one outstanding transaction at a time, with a sticky watchdog.
module axilm_arb
  import axilm_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [N-1:0]      M_REQ,
  input  logic [4*N-1:0]    M_WSTB,
  input  logic [32*N-1:0]   M_ADDR,
  input  logic [32*N-1:0]   M_WDATA,
  output logic [N-1:0]      M_GNT,
  output logic [N-1:0]      M_DONE,
  output logic [31:0]       M_RDATA,
  output logic [1:0]        M_RESP,
  output logic              BUS_ENA,
  output logic [3:0]        BUS_WSTB,
  output logic [31:0]       BUS_ADDR,
  output logic [31:0]       BUS_WDATA,
  input  logic              BUS_DONE,
  input  logic [31:0]       BUS_RDATA,
  input  logic [1:0]        BUS_RRESP,
  input  logic [1:0]        BUS_BRESP,
  output logic              TIMEOUT_ERR
);

  localparam int          IW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  arb_state_t    state_reg;
  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] owner_reg;
  logic          is_read_reg;
  logic [15:0]   wd_cnt_reg;
  logic [N-1:0]  gnt_reg;
  logic [N-1:0]  done_reg;
  logic [31:0]   rdata_reg;
  logic [1:0]    resp_reg;
  logic          bus_ena_reg;
  logic [3:0]    bus_wstb_reg;
  logic [31:0]   bus_addr_reg;
  logic [31:0]   bus_wdata_reg;
  logic          timeout_err_reg;

  logic [3:0]    wstb_arr  [N];
  logic [31:0]   addr_arr  [N];
  logic [31:0]   wdata_arr [N];

  logic [N-1:0]  win_onehot;
  logic [IW-1:0] win_idx;
  logic          win_any;
  logic          bus_done_hit;

  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign wstb_arr[gi]  = M_WSTB[4*gi +: 4];
    assign addr_arr[gi]  = M_ADDR[32*gi +: 32];
    assign wdata_arr[gi] = M_WDATA[32*gi +: 32];
  end

  axilm_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req     (M_REQ),
    .ptr     (ptr_reg),
    .win     (win_onehot),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  // A completion can already arrive during the enable cycle itself.
  assign bus_done_hit = BUS_DONE && (state_reg == ISSUE || state_reg == WAIT_DONE);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg       <= IDLE;
      ptr_reg         <= '0;
      owner_reg       <= '0;
      is_read_reg     <= 1'b0;
      wd_cnt_reg      <= '0;
      gnt_reg         <= '0;
      done_reg        <= '0;
      rdata_reg       <= '0;
      resp_reg        <= '0;
      bus_ena_reg     <= 1'b0;
      bus_wstb_reg    <= '0;
      bus_addr_reg    <= '0;
      bus_wdata_reg   <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      bus_ena_reg <= 1'b0;
      done_reg    <= '0;

      if (bus_done_hit) begin
        if (is_read_reg) begin
          rdata_reg <= BUS_RDATA;
        end
        resp_reg <= sel_resp(is_read_reg, BUS_RRESP, BUS_BRESP);
        done_reg <= gnt_reg;
      end

      case (state_reg)
        IDLE: begin
          if (win_any) begin
            gnt_reg       <= win_onehot;
            owner_reg     <= win_idx;
            bus_wstb_reg  <= wstb_arr[win_idx];
            bus_addr_reg  <= addr_arr[win_idx];
            bus_wdata_reg <= wdata_arr[win_idx];
            is_read_reg   <= ~|wstb_arr[win_idx];
            bus_ena_reg   <= 1'b1;
            wd_cnt_reg    <= '0;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          state_reg <= bus_done_hit ? RESP : WAIT_DONE;
        end
        WAIT_DONE: begin
          // The watchdog only flags; the engine is never abandoned.
          if (bus_done_hit) begin
            state_reg <= RESP;
          end else if (wd_cnt_reg == WD_LAST) begin
            timeout_err_reg <= 1'b1;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + 16'd1;
          end
        end
        RESP: begin
          gnt_reg   <= '0;
          ptr_reg   <= (owner_reg == IW'(N - 1)) ? '0 : owner_reg + 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign M_GNT       = gnt_reg;
  assign M_DONE      = done_reg;
  assign M_RDATA     = rdata_reg;
  assign M_RESP      = resp_reg;
  assign BUS_ENA     = bus_ena_reg;
  assign BUS_WSTB    = bus_wstb_reg;
  assign BUS_ADDR    = bus_addr_reg;
  assign BUS_WDATA   = bus_wdata_reg;
  assign TIMEOUT_ERR = timeout_err_reg;

endmodule

// File: tb/tb_axilm_arb.sv
// Scoreboard bench for axilm_arb: stimulus pushes expected transactions,
// a bus responder models the channel engines, a monitor checks outputs.
module tb_axilm_arb;

  localparam int N  = 4;
  localparam int TO = 16;

  logic            ACLK = 1'b0;
  logic            ARESETn = 1'b1;
  logic [N-1:0]    M_REQ = '0;
  logic [4*N-1:0]  M_WSTB = '0;
  logic [32*N-1:0] M_ADDR = '0;
  logic [32*N-1:0] M_WDATA = '0;
  logic [N-1:0]    M_GNT;
  logic [N-1:0]    M_DONE;
  logic [31:0]     M_RDATA;
  logic [1:0]      M_RESP;
  logic            BUS_ENA;
  logic [3:0]      BUS_WSTB;
  logic [31:0]     BUS_ADDR;
  logic [31:0]     BUS_WDATA;
  logic            BUS_DONE = 1'b0;
  logic [31:0]     BUS_RDATA = '0;
  logic [1:0]      BUS_RRESP = '0;
  logic [1:0]      BUS_BRESP = '0;
  logic            TIMEOUT_ERR;

  axilm_arb #(.N(N), .TIMEOUT(TO)) dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .M_REQ       (M_REQ),
    .M_WSTB      (M_WSTB),
    .M_ADDR      (M_ADDR),
    .M_WDATA     (M_WDATA),
    .M_GNT       (M_GNT),
    .M_DONE      (M_DONE),
    .M_RDATA     (M_RDATA),
    .M_RESP      (M_RESP),
    .BUS_ENA     (BUS_ENA),
    .BUS_WSTB    (BUS_WSTB),
    .BUS_ADDR    (BUS_ADDR),
    .BUS_WDATA   (BUS_WDATA),
    .BUS_DONE    (BUS_DONE),
    .BUS_RDATA   (BUS_RDATA),
    .BUS_RRESP   (BUS_RRESP),
    .BUS_BRESP   (BUS_BRESP),
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic [3:0]  wstb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        err;
    bit          b2b;
  } exp_t;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [1:0]  bresp;
  } rsp_t;

  exp_t        exp_q[$];
  rsp_t        rsp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          last_done_cyc = -100;
  logic        prev_ena = 1'b0;
  logic [31:0] model_rdata = '0;
  logic        model_err = 1'b0;
  exp_t        mon_e;
  rsp_t        cur_rsp;
  int          rsp_cd = 0;
  bit          rsp_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"},   32'(M_GNT), 32'd0);
    chk({tag, "_done"},  32'(M_DONE), 32'd0);
    chk({tag, "_rdata"}, M_RDATA, 32'd0);
    chk({tag, "_resp"},  32'(M_RESP), 32'd0);
    chk({tag, "_ena"},   32'(BUS_ENA), 32'd0);
    chk({tag, "_wstb"},  32'(BUS_WSTB), 32'd0);
    chk({tag, "_addr"},  BUS_ADDR, 32'd0);
    chk({tag, "_wdata"}, BUS_WDATA, 32'd0);
    chk({tag, "_err"},   32'(TIMEOUT_ERR), 32'd0);
  endtask

  task automatic push_txn(input int idx, input logic [3:0] w, input logic [31:0] a,
                          input logic [31:0] d, input int lat, input logic [31:0] rd,
                          input logic [1:0] rr, input logic [1:0] br, input bit b2b);
    exp_t e;
    rsp_t r;
    if (lat > TO) model_err = 1'b1;
    if (w == 4'h0) model_rdata = rd;
    e.idx = idx; e.addr = a; e.wstb = w; e.wdata = d;
    e.rdata = model_rdata;
    e.resp = (w == 4'h0) ? rr : br;
    e.err = model_err;
    e.b2b = b2b;
    r.lat = lat; r.rdata = rd; r.rresp = rr; r.bresp = br;
    exp_q.push_back(e);
    rsp_q.push_back(r);
  endtask

  task automatic set_req(input int i, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    M_WSTB[4*i +: 4]   = w;
    M_ADDR[32*i +: 32]  = a;
    M_WDATA[32*i +: 32] = d;
    M_REQ[i]            = 1'b1;
  endtask

  task automatic wait_done(input int idx, input bit drop);
    int n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!M_DONE[idx] && n < 200);
    if (!M_DONE[idx]) chk("done_wait_expired", 32'(M_DONE), 32'(1) << idx);
    if (drop) M_REQ[idx] = 1'b0;
  endtask

  // Channel-engine model: BUS_DONE follows BUS_ENA after the queued latency.
  always @(negedge ACLK) begin
    BUS_DONE = 1'b0;
    if (!ARESETn) begin
      rsp_pend = 1'b0;
    end else begin
      if (BUS_ENA) begin
        if (rsp_q.size() == 0) begin
          fail("bus_ena_unexpected");
        end else begin
          cur_rsp  = rsp_q.pop_front();
          rsp_cd   = cur_rsp.lat;
          rsp_pend = 1'b1;
        end
      end
      if (rsp_pend) begin
        if (rsp_cd == 0) begin
          BUS_DONE  = 1'b1;
          BUS_RDATA = cur_rsp.rdata;
          BUS_RRESP = cur_rsp.rresp;
          BUS_BRESP = cur_rsp.bresp;
          rsp_pend  = 1'b0;
        end else begin
          rsp_cd--;
        end
      end
    end
  end

  always @(negedge ACLK) begin
    cyc++;
    if (ARESETn) begin
      chk("gnt_onehot", 32'($countones(M_GNT) <= 1), 32'd1);
      if (BUS_ENA) begin
        chk("ena_single_cycle", 32'(prev_ena), 32'd0);
        if (exp_q.size() == 0) begin
          fail("issue_unexpected");
        end else begin
          mon_e = exp_q[0];
          chk("issue_gnt",   32'(M_GNT), 32'(1) << mon_e.idx);
          chk("issue_addr",  BUS_ADDR, mon_e.addr);
          chk("issue_wstb",  32'(BUS_WSTB), 32'(mon_e.wstb));
          chk("issue_wdata", BUS_WDATA, mon_e.wdata);
          if (mon_e.b2b) chk("b2b_gap", 32'(cyc - last_done_cyc), 32'd2);
        end
      end
      if (M_DONE != '0) begin
        if (exp_q.size() == 0) begin
          fail("done_unexpected");
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_owner", 32'(M_DONE), 32'(1) << mon_e.idx);
          chk("done_gnt_held", 32'(M_GNT), 32'(1) << mon_e.idx);
          chk("done_rdata", M_RDATA, mon_e.rdata);
          chk("done_resp", 32'(M_RESP), 32'(mon_e.resp));
          chk("done_timeout_err", 32'(TIMEOUT_ERR), 32'(mon_e.err));
          chk("done_addr_stable", BUS_ADDR, mon_e.addr);
          $display("txn req%0d addr=%h wstb=%h rdata=%h resp=%0d err=%0d",
                   mon_e.idx, BUS_ADDR, BUS_WSTB, M_RDATA, M_RESP, TIMEOUT_ERR);
        end
        last_done_cyc = cyc;
      end
      prev_ena = BUS_ENA;
    end else begin
      prev_ena = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got running, expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    #2 ARESETn = 1'b0;
    repeat (3) @(negedge ACLK);
    chk_zero("reset");
    ARESETn = 1'b1;

    // Single read on requester 1
    push_txn(1, 4'h0, 32'h1000_0010, 32'h0, 4, 32'hDEAD_BEEF, 2'b00, 2'b00, 1'b0);
    set_req(1, 4'h0, 32'h1000_0010, 32'h0);
    wait_done(1, 1'b1);

    // Write with SLVERR; read data on the bus must not reach M_RDATA
    push_txn(2, 4'hF, 32'h2000_0020, 32'h1234_5678, 2, 32'hFFFF_0000, 2'b00, 2'b10, 1'b0);
    set_req(2, 4'hF, 32'h2000_0020, 32'h1234_5678);
    wait_done(2, 1'b1);

    // Pointer at 3, requests 3 and 0: 3 first (done in ISSUE), then 0
    push_txn(3, 4'h0, 32'h3000_0030, 32'h0, 0, 32'hA5A5_0003, 2'b01, 2'b11, 1'b0);
    push_txn(0, 4'h3, 32'h0000_0040, 32'hCAFE_0000, 1, 32'h0, 2'b00, 2'b11, 1'b0);
    set_req(3, 4'h0, 32'h3000_0030, 32'h0);
    set_req(0, 4'h3, 32'h0000_0040, 32'hCAFE_0000);
    wait_done(3, 1'b1);
    wait_done(0, 1'b1);

    // Latency equal to TIMEOUT must not trip the watchdog
    push_txn(1, 4'h0, 32'h1000_0050, 32'h0, TO, 32'h5555_AAAA, 2'b11, 2'b00, 1'b0);
    set_req(1, 4'h0, 32'h1000_0050, 32'h0);
    wait_done(1, 1'b1);

    // One cycle longer trips it; the transaction still completes
    push_txn(2, 4'h0, 32'h2000_0060, 32'h0, TO + 1, 32'h0F0F_0F0F, 2'b00, 2'b01, 1'b0);
    set_req(2, 4'h0, 32'h2000_0060, 32'h0);
    wait_done(2, 1'b1);
    repeat (5) @(negedge ACLK);
    chk("timeout_sticky", 32'(TIMEOUT_ERR), 32'd1);

    // Reset while waiting for completion
    push_txn(3, 4'h0, 32'h3000_0070, 32'h0, 50, 32'h7777_7777, 2'b00, 2'b00, 1'b0);
    set_req(3, 4'h0, 32'h3000_0070, 32'h0);
    begin
      int n = 0;
      do begin
        @(negedge ACLK);
        n++;
      end while (!BUS_ENA && n < 20);
      if (!BUS_ENA) chk("ena_wait_expired", 32'(BUS_ENA), 32'd1);
    end
    repeat (3) @(negedge ACLK);
    ARESETn = 1'b0;
    #1;
    chk_zero("midreset");
    exp_q.delete();
    rsp_q.delete();
    M_REQ       = '0;
    model_rdata = '0;
    model_err   = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;

    // All four requesting: order 0,1,2,3,0 with one idle cycle between
    push_txn(0, 4'h0, 32'h0000_0100, 32'h0, 1, 32'h1111_0000, 2'b00, 2'b00, 1'b0);
    push_txn(1, 4'h1, 32'h0000_0104, 32'h0000_00AB, 0, 32'h0, 2'b00, 2'b00, 1'b1);
    push_txn(2, 4'h0, 32'h0000_0108, 32'h0, 2, 32'h2222_0002, 2'b01, 2'b00, 1'b1);
    push_txn(3, 4'hC, 32'h0000_010C, 32'hBEEF_0000, 3, 32'h0, 2'b00, 2'b10, 1'b1);
    push_txn(0, 4'h0, 32'h0000_0100, 32'h0, 1, 32'h3333_0000, 2'b11, 2'b00, 1'b1);
    set_req(0, 4'h0, 32'h0000_0100, 32'h0);
    set_req(1, 4'h1, 32'h0000_0104, 32'h0000_00AB);
    set_req(2, 4'h0, 32'h0000_0108, 32'h0);
    set_req(3, 4'hC, 32'h0000_010C, 32'hBEEF_0000);
    wait_done(0, 1'b0);
    wait_done(1, 1'b1);
    wait_done(2, 1'b1);
    wait_done(3, 1'b1);
    wait_done(0, 1'b1);

    repeat (3) @(negedge ACLK);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axilm_arb.md
# axilm_arb

Round-robin arbiter that shares one AXI4-Lite master's local bus between N requesters. Sits between the requesters and the master's local interface (BUS_ENA/BUS_WSTB/BUS_ADDR), which drives the read and write channel engines. Handles one outstanding transaction at a time: grant, issue a single-cycle enable, wait for completion, return data and response to the owner. Includes a watchdog that raises a sticky error flag.

## Interface
- N, 4, number of requesters (2..8)
- TIMEOUT, 1024, watchdog limit in cycles for BUS_DONE (≥2)
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous, active-low reset
- M_REQ  in  N  per-requester request level
- M_WSTB  in  4*N  byte strobes; all-zero = read
- M_ADDR  in  32*N  address
- M_WDATA  in  32*N  write data
- M_GNT  out  N  one-hot grant, held for the whole transaction
- M_DONE  out  N  one-cycle completion pulse to the owner
- M_RDATA  out  32  read data, valid with M_DONE
- M_RESP  out  2  RRESP (read) or BRESP (write), valid with M_DONE
- BUS_ENA  out  1  one-cycle transaction strobe
- BUS_WSTB  out  4  latched strobes
- BUS_ADDR  out  32  latched address
- BUS_WDATA  out  32  latched write data
- BUS_DONE  in  1  one-cycle pulse on the R or B handshake
- BUS_RDATA  in  32  read data, valid with BUS_DONE
- BUS_RRESP  in  2  read response
- BUS_BRESP  in  2  write response
- TIMEOUT_ERR  out  1  sticky watchdog flag

## Operation
- States: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE: if any M_REQ is set, pick the winner by round-robin starting at pointer ptr. Register M_GNT[win], BUS_ADDR/BUS_WSTB/BUS_WDATA from win's slice, and the is_read flag (~|wstb). Go to ISSUE.
- ISSUE: BUS_ENA=1 for exactly this cycle. Go to WAIT_DONE. A BUS_DONE seen in ISSUE is handled as in WAIT_DONE.
- WAIT_DONE: on BUS_DONE, capture M_RDATA=BUS_RDATA (reads only; writes leave it unchanged) and M_RESP=is_read?BUS_RRESP:BUS_BRESP. Go to RESP.
- RESP: M_DONE[owner]=1 for one cycle. M_GNT cleared at the end of the cycle. ptr = owner+1 mod N. Go to IDLE.
- M_REQ dropping mid-transaction is ignored: the transaction completes and M_DONE still pulses.
- The requester deasserts M_REQ on the edge where it samples M_DONE. A request still high in the following IDLE cycle is a new request, but is lower priority because of the pointer update.
- Watchdog: 16-bit counter, cleared when entering ISSUE, counts in WAIT_DONE. At count==TIMEOUT-1 without BUS_DONE, TIMEOUT_ERR=1 (sticky until reset). The FSM keeps waiting; the channel engine is never abandoned.
- Reset (async, any state): state=IDLE, ptr=0. All outputs 0: M_GNT, M_DONE, M_RDATA, M_RESP, BUS_ENA, BUS_WSTB, BUS_ADDR, BUS_WDATA, TIMEOUT_ERR.

## Timing
- M_REQ sampled at edge E0 (IDLE) → M_GNT and BUS_ENA high in cycle E0+1.
- BUS_DONE at edge Ed → M_DONE in cycle Ed+1 → IDLE at Ed+2.
- Minimum request-to-M_DONE: 3 cycles plus bus latency.
- Back-to-back grants: one IDLE cycle between transactions.
- BUS_* outputs are stable from ISSUE through RESP.
- BUS_ENA is never asserted outside ISSUE.
- All outputs are registered.

## Structure
- Shared package axilm_pkg holds:
  - state enum arb_state_t {IDLE, ISSUE, WAIT_DONE, RESP}
  - response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
- Sub-module axilm_rr_pick: combinational round-robin winner select. Inputs req[N] and ptr; outputs a one-hot winner and its index. The top contains the FSM, latches and watchdog.

## Test plan
- Single read: M_REQ[1]=1, M_WSTB[1]=0, M_ADDR[1]=32'h1000_0010; BUS_DONE 4 cycles after BUS_ENA with BUS_RDATA=32'hDEAD_BEEF, BUS_RRESP=0. → BUS_ENA one cycle with BUS_ADDR=32'h1000_0010; M_DONE[1] one cycle later with M_RDATA=32'hDEAD_BEEF, M_RESP=0.
- Write with error: M_WSTB[2]=4'hF, M_WDATA[2]=32'h1234_5678, BUS_BRESP=2'b10. → BUS_WDATA=32'h1234_5678; M_RESP=2'b10; M_RDATA unchanged.
- Fairness: all four M_REQ held high continuously. → grants in order 0,1,2,3,0; never two M_GNT bits set at once.
- Pointer wrap: ptr=3 with M_REQ=4'b1001. → grant 3, then grant 0.
- Watchdog: withhold BUS_DONE for TIMEOUT cycles. → TIMEOUT_ERR rises and stays high; a later BUS_DONE still completes with M_DONE.
- Reset mid-transaction: assert ARESETn=0 in WAIT_DONE. → all outputs 0 immediately; after release, next grant goes to requester 0 first.
